// File: rtl/ifetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   state_t        : sequencer FSM state encoding (3 bits)
//   CMD_*          : debug command bytes
//   BYTES_PER_WORD : payload bytes assembled into one instruction word
package ifetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_CNT  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP      = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/ifetch_sequencer_byte_word_assembler.sv
// Assembles a little-endian byte stream into instruction words and issues
// registered instruction-memory writes at consecutive word addresses.
//   clk, rst_n     : clock, async active-low reset
//   start          : restart at byte 0 / address 0 (new load)
//   byte_en        : accept byte_data this cycle
//   byte_data      : payload byte
//   word_complete  : combinational, high when the accepted byte finishes a word
//   wr_en          : one-cycle write strobe (cycle after the 4th byte)
//   wr_addr        : byte address of the write, word aligned
//   wr_data        : assembled word
module ifetch_sequencer_byte_word_assembler
    import ifetch_sequencer_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int IMEM_DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    output logic             word_complete,
    output logic             wr_en,
    output logic [NBITS-1:0] wr_addr,
    output logic [NBITS-1:0] wr_data
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [1:0]    byte_idx;
    logic [23:0]   shift_q;    // first three bytes of the word, byte 0 lowest
    logic [AW-1:0] word_addr;  // word index; wraps modulo IMEM_DEPTH

    assign word_complete = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            shift_q   <= '0;
            word_addr <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                byte_idx  <= '0;
                word_addr <= '0;
            end else if (byte_en) begin
                byte_idx <= byte_idx + 2'd1;
                if (word_complete) begin
                    wr_en     <= 1'b1;
                    wr_data   <= NBITS'({byte_data, shift_q});
                    wr_addr   <= NBITS'({word_addr, 2'b00});
                    word_addr <= (word_addr == AW'(IMEM_DEPTH - 1)) ? '0 : word_addr + 1'b1;
                end else begin
                    // shift right so byte k ends up in bits [8k+7:8k]
                    shift_q <= {byte_data, shift_q[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: decodes debug command bytes to load programs
// into instruction memory, free-run or single-step the fetch stage, detect
// halt, count enabled cycles and clear the PC.
//   i_clk, i_reset      : clock, async active-low reset
//   i_cmd_valid/_data   : command/payload byte stream, o_cmd_ready handshake
//   i_halt              : halt opcode fetched (RUN/STEP only)
//   o_enable/o_pc_write : fetch enable / memory read valid
//   o_pc_clear, o_err   : one-cycle pulses
//   o_mem_wr_*          : instruction-memory write port
//   o_cycles            : saturating enabled-cycle counter
//   o_halted            : high in HALTED
module ifetch_sequencer
    import ifetch_sequencer_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int IMEM_DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [7:0]       i_cmd_data,
    output logic             o_cmd_ready,
    input  logic             i_halt,
    output logic             o_enable,
    output logic             o_pc_write,
    output logic             o_pc_clear,
    output logic             o_mem_wr_en,
    output logic [NBITS-1:0] o_mem_wr_addr,
    output logic [NBITS-1:0] o_mem_wr_data,
    output logic [NBITS-1:0] o_cycles,
    output logic             o_halted,
    output logic             o_err
);

    state_t     state, state_nxt;
    logic [7:0] words_total, words_done;
    logic       accept, load_start, word_complete, cmd_err, cmd_clear;

    // o_cmd_ready is registered, so it already reflects the current state
    assign accept     = i_cmd_valid && o_cmd_ready;
    assign load_start = accept && (state == ST_LOAD_CNT) && (i_cmd_data != 8'd0);
    assign o_pc_write = o_enable;

    always_comb begin
        state_nxt = state;
        cmd_err   = 1'b0;
        cmd_clear = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                case (i_cmd_data)
                    CMD_LOAD:  state_nxt = ST_LOAD_CNT;
                    CMD_RUN:   state_nxt = ST_RUN;
                    CMD_STEP:  state_nxt = ST_STEP;
                    CMD_CLEAR: cmd_clear = 1'b1;
                    default:   cmd_err   = 1'b1;
                endcase
            end
            ST_LOAD_CNT: if (accept) begin
                state_nxt = (i_cmd_data == 8'd0) ? ST_IDLE : ST_LOAD_DATA;
            end
            ST_LOAD_DATA: if (word_complete && (words_done == words_total - 8'd1)) begin
                state_nxt = ST_IDLE;
            end
            ST_RUN:  if (i_halt) state_nxt = ST_HALTED;
            ST_STEP: state_nxt = i_halt ? ST_HALTED : ST_IDLE;
            ST_HALTED: if (accept) begin
                case (i_cmd_data)
                    CMD_CLEAR: begin
                        cmd_clear = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    CMD_LOAD:  state_nxt = ST_LOAD_CNT;
                    default:   cmd_err   = 1'b1;
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every output reads 0
    // while reset is held (including ready, which is otherwise high in IDLE).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            words_total <= '0;
            words_done  <= '0;
            o_cmd_ready <= 1'b0;
            o_enable    <= 1'b0;
            o_halted    <= 1'b0;
            o_pc_clear  <= 1'b0;
            o_err       <= 1'b0;
            o_cycles    <= '0;
        end else begin
            state       <= state_nxt;
            o_cmd_ready <= state_nxt inside {ST_IDLE, ST_LOAD_CNT, ST_LOAD_DATA, ST_HALTED};
            o_enable    <= state_nxt inside {ST_RUN, ST_STEP};
            o_halted    <= (state_nxt == ST_HALTED);
            o_pc_clear  <= cmd_clear;
            o_err       <= cmd_err;

            if (cmd_clear)
                o_cycles <= '0;
            else if ((state inside {ST_RUN, ST_STEP}) && (o_cycles != '1))
                o_cycles <= o_cycles + 1'b1;

            if (load_start) begin
                words_total <= i_cmd_data;
                words_done  <= '0;
            end else if (word_complete) begin
                words_done <= words_done + 8'd1;
            end
        end
    end

    ifetch_sequencer_byte_word_assembler #(
        .NBITS      (NBITS),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_asm (
        .clk           (i_clk),
        .rst_n         (i_reset),
        .start         (load_start),
        .byte_en       (accept && (state == ST_LOAD_DATA)),
        .byte_data     (i_cmd_data),
        .word_complete (word_complete),
        .wr_en         (o_mem_wr_en),
        .wr_addr       (o_mem_wr_addr),
        .wr_data       (o_mem_wr_data)
    );

endmodule
